// File: rtl/uart_mix_loader.sv
// uart_mix_loader: drains the chu_uart RX FIFO, parses 0xA5-framed operand
// packets, verifies the XOR checksum and presents c/x/d with valid/ack.
module uart_mix_loader #(
  parameter int CWORDS64    = 4,
  parameter int XWORDS32    = 2,
  parameter int DVSR        = 651,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic [4:0]                           addr,
  output logic [31:0]                          wr_data,
  output logic                                 write,
  output logic                                 read,
  input  logic [31:0]                          rd_data,
  output logic [CWORDS64*64-1:0]               c_out,
  output logic [XWORDS32*32-1:0]               x_out,
  output logic [$clog2(XWORDS32)*CWORDS64-1:0] d_out,
  output logic                                 frame_valid,
  input  logic                                 frame_ack,
  output logic                                 err_chk,
  output logic                                 err_timeout
);

  localparam int C_BYTES   = CWORDS64 * 8;
  localparam int X_BYTES   = XWORDS32 * 4;
  localparam int DW        = $clog2(XWORDS32) * CWORDS64;
  localparam int D_BYTES   = (DW + 7) / 8;
  localparam int PAY_BYTES = C_BYTES + X_BYTES + D_BYTES;
  localparam int C_BITS    = C_BYTES * 8;
  localparam int X_BITS    = X_BYTES * 8;
  localparam int CW        = $clog2(PAY_BYTES + 1);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    BAUD_SETUP,
    SYNC,
    PAYLOAD,
    CHECK,
    HOLD
  } state_t;

  state_t state, nxt;

  logic [PAY_BYTES*8-1:0] shadow;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          tcnt;
  logic [7:0]             chk;
  logic [7:0]             rx_byte;
  logic                   rx_ok;
  logic                   pop;
  logic                   last;
  logic                   tmo_hit;
  logic                   tmo;
  logic                   good;
  logic                   bad;
  logic                   unused;

  assign read    = 1'b0;
  assign rx_byte = rd_data[7:0];
  assign rx_ok   = !rd_data[8] && !reset;
  assign last    = (cnt == CW'(PAY_BYTES - 1));
  assign tmo_hit = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign unused  = ^{rd_data[31:9], shadow};

  // Bus outputs are combinational so a byte is popped in the cycle it is seen.
  always_comb begin
    nxt     = state;
    addr    = '0;
    wr_data = '0;
    write   = 1'b0;
    pop     = 1'b0;
    tmo     = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    if (!reset) begin
      unique case (state)
        BAUD_SETUP: begin
          addr    = 5'd1;
          wr_data = 32'(DVSR);
          write   = 1'b1;
          nxt     = SYNC;
        end
        SYNC: begin
          pop = rx_ok;
          if (pop && rx_byte == SYNC_BYTE) nxt = PAYLOAD;
        end
        PAYLOAD: begin
          pop = rx_ok;
          if (pop) begin
            if (last) nxt = CHECK;
          end else if (tmo_hit) begin
            tmo = 1'b1;
            nxt = SYNC;
          end
        end
        CHECK: begin
          pop = rx_ok;
          if (pop) begin
            if (rx_byte == chk) begin
              good = 1'b1;
              nxt  = HOLD;
            end else begin
              bad = 1'b1;
              nxt = SYNC;
            end
          end else if (tmo_hit) begin
            tmo = 1'b1;
            nxt = SYNC;
          end
        end
        HOLD: begin
          if (frame_ack && frame_valid) nxt = SYNC;
        end
        default: nxt = SYNC;
      endcase
      if (pop) begin
        addr  = 5'd3;
        write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BAUD_SETUP;
      cnt         <= '0;
      tcnt        <= '0;
      chk         <= '0;
      shadow      <= '0;
      c_out       <= '0;
      x_out       <= '0;
      d_out       <= '0;
      frame_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= nxt;
      err_chk     <= bad;
      err_timeout <= tmo;
      if (state == SYNC && pop && rx_byte == SYNC_BYTE) begin
        cnt  <= '0;
        chk  <= '0;
        tcnt <= '0;
      end
      if (state == PAYLOAD && pop) begin
        shadow[{cnt, 3'b000} +: 8] <= rx_byte;
        chk <= chk ^ rx_byte;
        cnt <= cnt + 1'b1;
      end
      // Idle counter only runs while a frame is partially received.
      if (state == PAYLOAD || state == CHECK) begin
        tcnt <= pop ? '0 : tcnt + 1'b1;
      end
      if (good) begin
        c_out       <= shadow[C_BITS-1:0];
        x_out       <= shadow[C_BITS +: X_BITS];
        d_out       <= shadow[C_BITS+X_BITS +: DW];
        frame_valid <= 1'b1;
      end
      if (state == HOLD && frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_mix_loader.sv
// Directed self-checking bench for uart_mix_loader with a behavioural
// chu_uart RX FIFO model behind the register interface.
module tb_uart_mix_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   addr;
  logic [31:0]  wr_data;
  logic         write;
  logic         read;
  logic [31:0]  rd_data = 32'h0000_0100;
  logic [255:0] c_out;
  logic [63:0]  x_out;
  logic [3:0]   d_out;
  logic         frame_valid;
  logic         frame_ack = 1'b0;
  logic         err_chk;
  logic         err_timeout;

  uart_mix_loader #(
    .CWORDS64(4), .XWORDS32(2), .DVSR(651), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .write(write), .read(read), .rd_data(rd_data),
    .c_out(c_out), .x_out(x_out), .d_out(d_out),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .err_chk(err_chk), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] CA = {128'h0, 128'h3274_9a1c_55aa_0ff0_d00d_beef_c0de_3645};
  localparam logic [63:0]  XA = 64'd16;
  localparam logic [7:0]   DA = 8'h09;
  localparam logic [255:0] CB =
    256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1122_3344_5566_7788_99aa_bbcc_ddee_ff00;
  localparam logic [63:0]  XB = 64'hffff_0000_1234_5678;
  localparam logic [7:0]   DB = 8'hf6;

  logic [7:0] fifo[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops = 0;
  int last_pop = 0;
  int chk_hi = 0;
  int tmo_hi = 0;
  bit pend = 0;
  bit pop_now = 0;

  always @(negedge clk) begin
    cyc++;
    pop_now = write && addr == 5'd3;
    if (pop_now) begin
      pops++;
      last_pop = cyc;
    end
    if (err_chk) chk_hi++;
    if (err_timeout) tmo_hi++;
    pend = pop_now;
  end

  always @(posedge clk) begin
    #1;
    if (pend && fifo.size() > 0) void'(fifo.pop_front());
    rd_data = 32'h0;
    rd_data[8] = (fifo.size() == 0);
    if (fifo.size() != 0) rd_data[7:0] = fifo[0];
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drv();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input logic [255:0] c, input logic [63:0] x,
                            input logic [7:0] d, input logic [7:0] flip);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    fifo.push_back(8'hA5);
    for (int i = 0; i < 32; i++) begin
      b = c[i*8 +: 8];
      fifo.push_back(b);
      s ^= b;
    end
    for (int i = 0; i < 8; i++) begin
      b = x[i*8 +: 8];
      fifo.push_back(b);
      s ^= b;
    end
    fifo.push_back(d);
    s ^= d;
    fifo.push_back(s ^ flip);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_ack();
    drv();
    frame_ack = 1'b1;
    drv();
    frame_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({addr, wr_data, write, read} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got addr=%h wr=%h w=%b want 0", addr, wr_data, write);
    end
    n_cmp++;
    if ({frame_valid, err_chk, err_timeout} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {frame_valid, err_chk, err_timeout});
    end
    n_cmp++;
    if ({c_out, x_out, d_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_ops: got c=%h x=%h d=%h want 0", c_out, x_out, d_out);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    n_cmp++;
    if ({addr, wr_data, write} !== {5'd1, 32'd651, 1'b1}) begin
      n_bad++;
      $display("FAIL baud_setup: got a=%0d wr=%0d w=%b want 1/651/1", addr, wr_data, write);
    end
    tick();
    n_cmp++;
    if ({addr, write} !== {5'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL setup_once: got a=%0d w=%b want 0/0", addr, write);
    end
  endtask

  task automatic test_valid_frame();
    int p0;
    bit ok;
    p0 = pops;
    push_frame(CA, XA, DA, 8'h00);
    wait_valid(100, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL valid_seen: got 0 want 1");
    end
    n_cmp++;
    if (cyc !== last_pop + 1) begin
      n_bad++;
      $display("FAIL valid_latency: got cyc %0d want %0d", cyc, last_pop + 1);
    end
    n_cmp++;
    if (pops - p0 !== 43) begin
      n_bad++;
      $display("FAIL valid_pops: got %0d want 43", pops - p0);
    end
    n_cmp++;
    if (c_out !== CA || x_out !== XA) begin
      n_bad++;
      $display("FAIL valid_cx: got c=%h x=%h want c=%h x=%h", c_out, x_out, CA, XA);
    end
    n_cmp++;
    if (d_out !== 4'b1001) begin
      n_bad++;
      $display("FAIL valid_d: got %b want 1001", d_out);
    end
    do_ack();
    n_cmp++;
    if (frame_valid !== 1'b0 || c_out !== CA) begin
      n_bad++;
      $display("FAIL ack_clear: got fv=%b c=%h want 0 c=%h", frame_valid, c_out, CA);
    end
  endtask

  task automatic test_bad_checksum();
    int p0;
    int c0;
    bit fv_seen;
    p0 = pops;
    c0 = chk_hi;
    fv_seen = 0;
    push_frame(CB, XB, DB, 8'h01);
    for (int i = 0; i < 80; i++) begin
      tick();
      fv_seen |= frame_valid;
    end
    n_cmp++;
    if (chk_hi - c0 !== 1) begin
      n_bad++;
      $display("FAIL chk_pulse: got %0d high cycles want 1", chk_hi - c0);
    end
    n_cmp++;
    if (fv_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL chk_novalid: got 1 want 0");
    end
    n_cmp++;
    if (c_out !== CA || x_out !== XA || d_out !== 4'h9) begin
      n_bad++;
      $display("FAIL chk_keep: got c=%h x=%h d=%h want old", c_out, x_out, d_out);
    end
    n_cmp++;
    if (pops - p0 !== 43) begin
      n_bad++;
      $display("FAIL chk_pops: got %0d want 43", pops - p0);
    end
  endtask

  task automatic test_garbage();
    int p0;
    bit ok;
    p0 = pops;
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    fifo.push_back(8'h5A);
    push_frame(CB, XB, DB, 8'h00);
    wait_valid(100, ok);
    n_cmp++;
    if (!ok || pops - p0 !== 46) begin
      n_bad++;
      $display("FAIL garbage_pops: got ok=%b pops=%0d want 1/46", ok, pops - p0);
    end
    n_cmp++;
    if (c_out !== CB || x_out !== XB || d_out !== 4'h6) begin
      n_bad++;
      $display("FAIL garbage_ops: got c=%h x=%h d=%h", c_out, x_out, d_out);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int t0;
    int idle;
    int at;
    bit got;
    bit ok;
    bit fv_seen;
    t0 = tmo_hi;
    idle = 0;
    at = -1;
    got = 0;
    fv_seen = 0;
    fifo.push_back(8'hA5);
    for (int i = 0; i < 10; i++) fifo.push_back(CA[i*8 +: 8]);
    for (int i = 0; i < 200; i++) begin
      tick();
      fv_seen |= frame_valid;
      if (pop_now) idle = 0;
      else idle++;
      if (err_timeout && !got) begin
        got = 1;
        at = idle;
      end
    end
    // Counter reaches 100 at the end of idle cycle 100; pulse shows next cycle.
    n_cmp++;
    if (at !== 101) begin
      n_bad++;
      $display("FAIL tmo_when: got idle %0d want 101", at);
    end
    n_cmp++;
    if (tmo_hi - t0 !== 1 || fv_seen) begin
      n_bad++;
      $display("FAIL tmo_pulse: got %0d cycles fv=%b want 1/0", tmo_hi - t0, fv_seen);
    end
    push_frame(CA, XA, DA, 8'h00);
    wait_valid(100, ok);
    n_cmp++;
    if (!ok || c_out !== CA || x_out !== XA || d_out !== 4'h9) begin
      n_bad++;
      $display("FAIL tmo_reload: got ok=%b c=%h x=%h d=%h", ok, c_out, x_out, d_out);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int p0;
    bit ok;
    push_frame(CB, XB, DB, 8'h00);
    push_frame(CA, XA, DA, 8'h00);
    wait_valid(100, ok);
    n_cmp++;
    if (!ok || c_out !== CB) begin
      n_bad++;
      $display("FAIL b2b_first: got ok=%b c=%h want c=%h", ok, c_out, CB);
    end
    p0 = pops;
    repeat (20) tick();
    n_cmp++;
    if (pops - p0 !== 0 || fifo.size() !== 43) begin
      n_bad++;
      $display("FAIL hold_nopop: got pops=%0d fifo=%0d want 0/43", pops - p0, fifo.size());
    end
    n_cmp++;
    if (frame_valid !== 1'b1 || c_out !== CB || x_out !== XB) begin
      n_bad++;
      $display("FAIL hold_stable: got fv=%b c=%h x=%h", frame_valid, c_out, x_out);
    end
    do_ack();
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ack: got fv=%b want 0", frame_valid);
    end
    drv();
    frame_ack = 1'b1;
    drv();
    frame_ack = 1'b0;
    wait_valid(100, ok);
    n_cmp++;
    if (!ok || c_out !== CA || x_out !== XA || d_out !== 4'h9) begin
      n_bad++;
      $display("FAIL b2b_second: got ok=%b c=%h x=%h d=%h", ok, c_out, x_out, d_out);
    end
    n_cmp++;
    if (pops - p0 !== 43) begin
      n_bad++;
      $display("FAIL b2b_pops: got %0d want 43", pops - p0);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    int p0;
    bit hit;
    bit ok;
    p0 = pops;
    hit = 0;
    push_frame(CB, XB, DB, 8'h00);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pops - p0 >= 21) begin
        hit = 1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL mid_reach: got %0d pops want 21", pops - p0);
    end
    drv();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({addr, wr_data, write, read, frame_valid, err_chk, err_timeout} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_ctl: got a=%0d w=%b fv=%b", addr, write, frame_valid);
    end
    n_cmp++;
    if ({c_out, x_out, d_out} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_ops: got c=%h x=%h d=%h want 0", c_out, x_out, d_out);
    end
    fifo.delete();
    drv();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({addr, wr_data, write} !== {5'd1, 32'd651, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_setup: got a=%0d wr=%0d w=%b", addr, wr_data, write);
    end
    push_frame(CB, XB, DB, 8'h00);
    wait_valid(100, ok);
    n_cmp++;
    if (!ok || c_out !== CB || x_out !== XB || d_out !== 4'h6) begin
      n_bad++;
      $display("FAIL mid_reload: got ok=%b c=%h d=%h", ok, c_out, d_out);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
